// File: rtl/sm4_key_expand.sv
// sm4_key_expand: SM4 key schedule, one round per clock.
//
// Loads the 128-bit master key on an accepted start and expands it into 32
// round keys. The keys are held in an internal register file. Two
// combinational read ports serve the downstream round pipeline:
//   rk1 = rk[i]       encryption order
//   rk2 = rk[31 - i]  decryption order
// i is taken from rd_idx[1:5].
//
// Ports
//   K_clk              clock, rising edge
//   K_rst              asynchronous reset, active high
//   K_start            start request, ignored while expanding
//   MK0..MK3   [0:31]  master key words, MK0 most significant
//   rd_idx     [0:5]   round index; bit 0 is ignored
//   rk1, rk2   [0:31]  encrypt / decrypt round key for rd_idx
//   K_busy             expansion in progress
//   K_valid            all 32 round keys are valid
//
// Vectors use [0:n] numbering with bit 0 as the MSB. The numeric value is the
// usual one, so the internal math uses [31:0] locals.
//
// state  | meaning
// IDLE   | after reset, waiting for K_start
// EXPAND | one round key produced per edge, cnt = round being written
// DONE   | rk[0..31] valid, K_start reloads and re-expands

module sm4_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [7:0] SBOX [0:255] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  assign dout = SBOX[din];
endmodule

module sm4_key_expand (
  input  logic        K_clk,
  input  logic        K_rst,
  input  logic        K_start,
  input  logic [0:31] MK0,
  input  logic [0:31] MK1,
  input  logic [0:31] MK2,
  input  logic [0:31] MK3,
  input  logic [0:5]  rd_idx,
  output logic [0:31] rk1,
  output logic [0:31] rk2,
  output logic        K_busy,
  output logic        K_valid
);
  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        load, step;
  logic [4:0]  cnt;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] rk [0:31];

  logic [7:0]  ck_base;
  logic [31:0] ck;
  logic [31:0] t_in, tau, lin, rk_new;
  logic [4:0]  idx;
  logic        idx_msb_unused;

  // CK byte j of round i is 28*i + 7*j mod 256; 8-bit arithmetic wraps.
  assign ck_base = {3'b000, cnt} * 8'd28;
  assign ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};

  assign t_in = k1 ^ k2 ^ k3 ^ ck;

  sm4_sbox u_sbox0 (.din(t_in[31:24]), .dout(tau[31:24]));
  sm4_sbox u_sbox1 (.din(t_in[23:16]), .dout(tau[23:16]));
  sm4_sbox u_sbox2 (.din(t_in[15:8]),  .dout(tau[15:8]));
  sm4_sbox u_sbox3 (.din(t_in[7:0]),   .dout(tau[7:0]));

  // Key-schedule linear layer: b ^ (b <<< 13) ^ (b <<< 23).
  assign lin    = tau ^ {tau[18:0], tau[31:19]} ^ {tau[8:0], tau[31:9]};
  assign rk_new = k0 ^ lin;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (K_start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        if (K_start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge K_clk or posedge K_rst) begin
    if (K_rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      k0    <= 32'd0;
      k1    <= 32'd0;
      k2    <= 32'd0;
      k3    <= 32'd0;
      for (int i = 0; i < 32; i++) rk[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        k0  <= MK0 ^ FK0;
        k1  <= MK1 ^ FK1;
        k2  <= MK2 ^ FK2;
        k3  <= MK3 ^ FK3;
        cnt <= 5'd0;
      end else if (step) begin
        rk[cnt] <= rk_new;
        k0      <= k1;
        k1      <= k2;
        k2      <= k3;
        k3      <= rk_new;
        // Wraps to 0 on the last round; reloaded anyway on the next start.
        cnt     <= cnt + 5'd1;
      end
    end
  end

  // rd_idx[0] is the pipeline counter's overflow bit; indices 32..63 alias.
  assign idx_msb_unused = rd_idx[0];
  assign idx            = rd_idx[1:5];

  assign rk1 = rk[idx];
  assign rk2 = rk[5'd31 - idx];

  assign K_busy  = (state == EXPAND);
  assign K_valid = (state == DONE);
endmodule
